// File: rtl/fll_wordcnt_monitor.sv
// Per-channel master/local bitclk word-count difference monitor for FLL control.
// Raises speedup/slowdown level interrupts with hysteresis around a shared threshold.
module fll_wordcnt_monitor #(
  parameter int unsigned N_CH          = 2,
  parameter int unsigned BITS_PER_WORD = 32,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                  CLK_IP_i,
  input  logic                  RST_IP_n_i,
  input  logic [N_CH-1:0]       bitclk_master_i,
  input  logic [N_CH-1:0]       bitclk_local_i,
  input  logic [N_CH-1:0]       enable_i,
  input  logic [CNT_W-2:0]      thresh_i,
  input  logic [N_CH-1:0]       clr_i,
  output logic [N_CH-1:0]       speedup_o,
  output logic [N_CH-1:0]       slowdown_o,
  output logic [N_CH*CNT_W-1:0] diff_o,
  output logic [N_CH-1:0]       overflow_o
);

  localparam int unsigned BitW = $clog2(BITS_PER_WORD);
  localparam logic [BitW-1:0] BitMax = BitW'(BITS_PER_WORD - 1);
  localparam logic signed [CNT_W-1:0] DiffMax = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] DiffMin = {1'b1, {(CNT_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StTrack, StSpeedup, StSlowdown} state_e;

  // A zero threshold would make TRACK unreachable, so it behaves as 1.
  logic signed [CNT_W-1:0] thr_pos, thr_neg;
  always_comb begin
    thr_pos = (thresh_i == '0) ? CNT_W'(1) : {1'b0, thresh_i};
    thr_neg = -thr_pos;
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [SYNC_STAGES-1:0]  m_sync_q, l_sync_q;
    logic                    m_prev_q, l_prev_q;
    logic                    m_edge, l_edge;
    logic [BitW-1:0]         m_cnt_q, m_cnt_d, l_cnt_q, l_cnt_d;
    logic                    m_tick_q, m_tick_d, l_tick_q, l_tick_d;
    logic signed [CNT_W-1:0] diff_q, diff_d;
    logic                    ovf_q, ovf_d;
    state_e                  state_q, state_d;
    logic                    speedup_q, slowdown_q;

    assign m_edge = m_sync_q[SYNC_STAGES-1] & ~m_prev_q;
    assign l_edge = l_sync_q[SYNC_STAGES-1] & ~l_prev_q;

    always_comb begin
      state_d  = state_q;
      m_cnt_d  = m_cnt_q;
      l_cnt_d  = l_cnt_q;
      m_tick_d = 1'b0;
      l_tick_d = 1'b0;
      diff_d   = diff_q;
      ovf_d    = ovf_q;
      if (!enable_i[k]) begin
        state_d = StIdle;
        m_cnt_d = '0;
        l_cnt_d = '0;
        diff_d  = '0;
        ovf_d   = 1'b0;
      end else if (state_q == StIdle) begin
        state_d = StTrack;
      end else if (clr_i[k]) begin
        state_d = StTrack;
        m_cnt_d = '0;
        l_cnt_d = '0;
        diff_d  = '0;
        ovf_d   = 1'b0;
      end else begin
        if (m_edge) begin
          m_tick_d = (m_cnt_q == BitMax);
          m_cnt_d  = (m_cnt_q == BitMax) ? '0 : m_cnt_q + BitW'(1);
        end
        if (l_edge) begin
          l_tick_d = (l_cnt_q == BitMax);
          l_cnt_d  = (l_cnt_q == BitMax) ? '0 : l_cnt_q + BitW'(1);
        end
        // Simultaneous word ticks cancel out.
        if (m_tick_q && !l_tick_q) begin
          if (diff_q == DiffMax) ovf_d = 1'b1;
          else                   diff_d = diff_q + CNT_W'(1);
        end else if (l_tick_q && !m_tick_q) begin
          if (diff_q == DiffMin) ovf_d = 1'b1;
          else                   diff_d = diff_q - CNT_W'(1);
        end
        case (state_q)
          StTrack: begin
            if (diff_q >= thr_pos)      state_d = StSpeedup;
            else if (diff_q <= thr_neg) state_d = StSlowdown;
          end
          StSpeedup:  if (diff_q[CNT_W-1] || diff_q == '0) state_d = StTrack;
          StSlowdown: if (!diff_q[CNT_W-1]) state_d = StTrack;
          default:    state_d = StTrack;
        endcase
      end
    end

    always_ff @(posedge CLK_IP_i or negedge RST_IP_n_i) begin
      if (!RST_IP_n_i) begin
        m_sync_q   <= '0;
        l_sync_q   <= '0;
        m_prev_q   <= 1'b0;
        l_prev_q   <= 1'b0;
        m_cnt_q    <= '0;
        l_cnt_q    <= '0;
        m_tick_q   <= 1'b0;
        l_tick_q   <= 1'b0;
        diff_q     <= '0;
        ovf_q      <= 1'b0;
        state_q    <= StIdle;
        speedup_q  <= 1'b0;
        slowdown_q <= 1'b0;
      end else begin
        m_sync_q   <= {m_sync_q[SYNC_STAGES-2:0], bitclk_master_i[k]};
        l_sync_q   <= {l_sync_q[SYNC_STAGES-2:0], bitclk_local_i[k]};
        m_prev_q   <= m_sync_q[SYNC_STAGES-1];
        l_prev_q   <= l_sync_q[SYNC_STAGES-1];
        m_cnt_q    <= m_cnt_d;
        l_cnt_q    <= l_cnt_d;
        m_tick_q   <= m_tick_d;
        l_tick_q   <= l_tick_d;
        diff_q     <= diff_d;
        ovf_q      <= ovf_d;
        state_q    <= state_d;
        speedup_q  <= (state_d == StSpeedup);
        slowdown_q <= (state_d == StSlowdown);
      end
    end

    assign speedup_o[k]                 = speedup_q;
    assign slowdown_o[k]                = slowdown_q;
    assign overflow_o[k]                = ovf_q;
    assign diff_o[k*CNT_W +: CNT_W]     = diff_q;
  end

endmodule

// File: tb/tb_fll_wordcnt_monitor.sv
// Directed bench for fll_wordcnt_monitor: bitclk generators plus per-scenario check tasks.
module tb_fll_wordcnt_monitor;
  localparam int Bpw = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] bm = '0, bl = '0, enable = '0, clr = '0;
  logic [6:0] thresh = 7'd3;
  logic [1:0] speedup, slowdown, overflow;
  logic [15:0] diff;

  int checks = 0, failures = 0;
  int cyc_n = 0;

  // Bitclk generator state, one entry per channel.
  int m_per[2] = '{10, 10};
  int l_per[2] = '{10, 10};
  int m_ph[2], l_ph[2], m_edges[2], l_edges[2], mdl_diff[2], m_word_cyc[2], l_word_cyc[2];
  bit m_on[2], l_on[2];

  fll_wordcnt_monitor #(
    .N_CH(2), .BITS_PER_WORD(Bpw), .CNT_W(8), .SYNC_STAGES(2)
  ) dut (
    .CLK_IP_i       (clk),
    .RST_IP_n_i     (rst_n),
    .bitclk_master_i(bm),
    .bitclk_local_i (bl),
    .enable_i       (enable),
    .thresh_i       (thresh),
    .clr_i          (clr),
    .speedup_o      (speedup),
    .slowdown_o     (slowdown),
    .diff_o         (diff),
    .overflow_o     (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Bitclks change on the falling edge; the model counts words per side.
  initial begin : bitclk_gen
    bit nm, nl, mw, lw;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        nm = m_on[c] && (m_ph[c] < m_per[c] / 2);
        nl = l_on[c] && (l_ph[c] < l_per[c] / 2);
        m_ph[c] = m_on[c] ? ((m_ph[c] + 1 >= m_per[c]) ? 0 : m_ph[c] + 1) : 0;
        l_ph[c] = l_on[c] ? ((l_ph[c] + 1 >= l_per[c]) ? 0 : l_ph[c] + 1) : 0;
        mw = 1'b0;
        lw = 1'b0;
        if (nm && !bm[c]) begin
          m_edges[c]++;
          if (m_edges[c] % Bpw == 0) begin mw = 1'b1; m_word_cyc[c] = cyc_n; end
        end
        if (nl && !bl[c]) begin
          l_edges[c]++;
          if (l_edges[c] % Bpw == 0) begin lw = 1'b1; l_word_cyc[c] = cyc_n; end
        end
        mdl_diff[c] += int'(mw) - int'(lw);
        bm[c] = nm;
        bl[c] = nl;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int dval(input int c);
    logic signed [7:0] v;
    v = diff[c*8 +: 8];
    return int'(v);
  endfunction

  task automatic clear_ch(input int c);
    m_on[c] = 1'b0;
    l_on[c] = 1'b0;
    repeat (8) cyc();
    clr[c] = 1'b1;
    cyc();
    clr[c] = 1'b0;
    m_edges[c] = 0;
    l_edges[c] = 0;
    mdl_diff[c] = 0;
    cyc();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) cyc();
    checks++; if (diff !== 16'h0) begin failures++; $display("FAIL reset_diff got=%h exp=0", diff); end
    checks++; if (speedup !== 2'b00) begin failures++; $display("FAIL reset_speedup got=%b exp=00", speedup); end
    checks++; if (slowdown !== 2'b00) begin failures++; $display("FAIL reset_slowdown got=%b exp=00", slowdown); end
    checks++; if (overflow !== 2'b00) begin failures++; $display("FAIL reset_overflow got=%b exp=00", overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    enable = 2'b11;
    repeat (2) cyc();
  endtask

  task automatic test_track_lock();
    int max_abs, v;
    bit irq;
    clear_ch(0);
    thresh = 7'd3;
    max_abs = 0;
    irq = 1'b0;
    m_per[0] = 10;
    l_per[0] = 10;
    m_on[0] = 1'b1;
    repeat (3) cyc();
    l_on[0] = 1'b1;
    for (int i = 0; i < 34000 && m_edges[0] < 100 * Bpw; i++) begin
      cyc();
      v = dval(0);
      if (v < 0) v = -v;
      if (v > max_abs) max_abs = v;
      if (speedup[0] || slowdown[0]) irq = 1'b1;
    end
    m_on[0] = 1'b0;
    l_on[0] = 1'b0;
    checks++; if (m_edges[0] < 100 * Bpw) begin failures++; $display("FAIL lock_timeout edges=%0d exp=%0d", m_edges[0], 100 * Bpw); end
    repeat (8) cyc();
    checks++; if (max_abs > 1) begin failures++; $display("FAIL lock_maxabs got=%0d exp<=1", max_abs); end
    checks++; if (irq) begin failures++; $display("FAIL lock_irq got=1 exp=0"); end
    // Local stops one word short of the master.
    checks++; if (dval(0) != 1) begin failures++; $display("FAIL lock_final_diff got=%0d exp=1", dval(0)); end
  endtask

  task automatic test_speedup();
    int exp_c, got_c;
    bit armed, done;
    clear_ch(0);
    thresh = 7'd3;
    m_per[0] = 10;
    l_per[0] = 11;
    m_on[0] = 1'b1;
    l_on[0] = 1'b1;
    armed = 0; done = 0; exp_c = -1; got_c = -2;
    for (int i = 0; i < 16000 && !done; i++) begin
      cyc();
      if (!armed && mdl_diff[0] >= 3) begin armed = 1; exp_c = m_word_cyc[0] + 5; end
      if (speedup[0]) begin done = 1; got_c = cyc_n; end
    end
    checks++; if (got_c != exp_c) begin failures++; $display("FAIL speedup_rise_cycle got=%0d exp=%0d", got_c, exp_c); end
    l_per[0] = 9;
    armed = 0; done = 0; exp_c = -1; got_c = -2;
    for (int i = 0; i < 16000 && !done; i++) begin
      cyc();
      if (!armed && mdl_diff[0] <= 0) begin armed = 1; exp_c = l_word_cyc[0] + 5; end
      if (!speedup[0]) begin done = 1; got_c = cyc_n; end
    end
    checks++; if (got_c != exp_c) begin failures++; $display("FAIL speedup_fall_cycle got=%0d exp=%0d", got_c, exp_c); end
    m_on[0] = 1'b0;
    l_on[0] = 1'b0;
  endtask

  task automatic test_simultaneous();
    bit moved;
    clear_ch(0);
    thresh = 7'd3;
    m_per[0] = 4;
    l_per[0] = 4;
    m_on[0] = 1'b1;
    for (int i = 0; i < 300 && m_edges[0] < Bpw; i++) cyc();
    m_on[0] = 1'b0;
    repeat (8) cyc();
    checks++; if (dval(0) != 1) begin failures++; $display("FAIL simul_pre_diff got=%0d exp=1", dval(0)); end
    m_on[0] = 1'b1;
    l_on[0] = 1'b1;
    moved = 1'b0;
    for (int i = 0; i < 600 && m_edges[0] < 3 * Bpw; i++) begin
      cyc();
      if (dval(0) != 1) moved = 1'b1;
    end
    m_on[0] = 1'b0;
    l_on[0] = 1'b0;
    repeat (8) cyc();
    checks++; if (moved || dval(0) != 1) begin failures++; $display("FAIL simul_diff got=%0d moved=%0b exp=1", dval(0), moved); end
    checks++; if (speedup[0] !== 1'b0) begin failures++; $display("FAIL simul_no_irq got=%b exp=0", speedup[0]); end
    // Threshold 0 acts as 1, applied the cycle after the change.
    thresh = 7'd0;
    cyc();
    checks++; if (speedup[0] !== 1'b1) begin failures++; $display("FAIL thresh0_speedup got=%b exp=1", speedup[0]); end
    thresh = 7'd3;
    repeat (3) cyc();
    checks++; if (speedup[0] !== 1'b1) begin failures++; $display("FAIL hysteresis_hold got=%b exp=1", speedup[0]); end
    m_on[0] = 1'b1;
    repeat (20) cyc();
    enable[0] = 1'b0;
    cyc();
    checks++; if (dval(0) != 0 || speedup[0] !== 1'b0) begin
      failures++; $display("FAIL disable_midword diff=%0d speedup=%b exp=0/0", dval(0), speedup[0]);
    end
    m_on[0] = 1'b0;
    repeat (4) cyc();
    enable[0] = 1'b1;
    cyc();
  endtask

  task automatic test_saturation();
    int exp_c, got_c;
    bit armed, done, mid;
    clear_ch(0);
    thresh = 7'd127;
    m_per[0] = 4;
    m_on[0] = 1'b1;
    armed = 0; done = 0; mid = 0; exp_c = -1; got_c = -2;
    for (int i = 0; i < 17000 && !done; i++) begin
      cyc();
      if (!mid && m_edges[0] == 127 * Bpw + 16) begin
        mid = 1;
        checks++; if (dval(0) != 127 || overflow[0] !== 1'b0) begin
          failures++; $display("FAIL sat_at_127 diff=%0d ovf=%b exp=127/0", dval(0), overflow[0]);
        end
      end
      if (!armed && m_edges[0] >= 128 * Bpw) begin armed = 1; exp_c = m_word_cyc[0] + 4; end
      if (overflow[0]) begin done = 1; got_c = cyc_n; end
    end
    checks++; if (got_c != exp_c) begin failures++; $display("FAIL ovf_rise_cycle got=%0d exp=%0d", got_c, exp_c); end
    repeat (200) cyc();
    m_on[0] = 1'b0;
    repeat (8) cyc();
    checks++; if (dval(0) != 127) begin failures++; $display("FAIL sat_hold got=%0d exp=127", dval(0)); end
    checks++; if (overflow[0] !== 1'b1 || speedup[0] !== 1'b1) begin
      failures++; $display("FAIL sat_flags ovf=%b speedup=%b exp=1/1", overflow[0], speedup[0]);
    end
    clr[0] = 1'b1;
    cyc();
    clr[0] = 1'b0;
    checks++; if (overflow[0] !== 1'b0 || dval(0) != 0 || speedup[0] !== 1'b0) begin
      failures++; $display("FAIL sat_clear ovf=%b diff=%0d speedup=%b exp=0/0/0", overflow[0], dval(0), speedup[0]);
    end
    thresh = 7'd3;
    cyc();
  endtask

  task automatic test_clear_independent();
    clear_ch(0);
    clear_ch(1);
    thresh = 7'd3;
    m_per[0] = 4;
    l_per[1] = 4;
    m_on[0] = 1'b1;
    l_on[1] = 1'b1;
    for (int i = 0; i < 2000 && (m_on[0] || l_on[1]); i++) begin
      cyc();
      if (m_edges[0] >= Bpw) m_on[0] = 1'b0;
      if (mdl_diff[1] <= -4) l_on[1] = 1'b0;
    end
    m_on[0] = 1'b0;
    l_on[1] = 1'b0;
    repeat (10) cyc();
    checks++; if (dval(1) != -4 || slowdown[1] !== 1'b1) begin
      failures++; $display("FAIL ch1_slowdown diff=%0d slowdown=%b exp=-4/1", dval(1), slowdown[1]);
    end
    checks++; if (dval(0) != 1 || speedup[0] !== 1'b0 || slowdown[0] !== 1'b0) begin
      failures++; $display("FAIL ch0_track diff=%0d up=%b down=%b exp=1/0/0", dval(0), speedup[0], slowdown[0]);
    end
    clr[1] = 1'b1;
    cyc();
    clr[1] = 1'b0;
    checks++; if (dval(1) != 0 || slowdown[1] !== 1'b0) begin
      failures++; $display("FAIL ch1_clear diff=%0d slowdown=%b exp=0/0", dval(1), slowdown[1]);
    end
    checks++; if (dval(0) != 1 || speedup[0] !== 1'b0 || slowdown[0] !== 1'b0) begin
      failures++; $display("FAIL ch0_unchanged diff=%0d up=%b down=%b exp=1/0/0", dval(0), speedup[0], slowdown[0]);
    end
  endtask

  task automatic test_reset_midop();
    clear_ch(0);
    thresh = 7'd3;
    m_per[0] = 4;
    m_on[0] = 1'b1;
    for (int i = 0; i < 1000 && mdl_diff[0] < 5; i++) cyc();
    m_on[0] = 1'b0;
    repeat (10) cyc();
    checks++; if (dval(0) != 5 || speedup[0] !== 1'b1) begin
      failures++; $display("FAIL midop_pre diff=%0d speedup=%b exp=5/1", dval(0), speedup[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (diff !== 16'h0 || speedup !== 2'b00 || slowdown !== 2'b00 || overflow !== 2'b00) begin
      failures++;
      $display("FAIL midop_async diff=%h up=%b down=%b ovf=%b exp=all 0", diff, speedup, slowdown, overflow);
    end
    enable = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) cyc();
    checks++; if (diff !== 16'h0 || speedup !== 2'b00 || slowdown !== 2'b00 || overflow !== 2'b00) begin
      failures++;
      $display("FAIL midop_after diff=%h up=%b down=%b ovf=%b exp=all 0", diff, speedup, slowdown, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_track_lock();
    test_speedup();
    test_simultaneous();
    test_saturation();
    test_clear_independent();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fll_wordcnt_monitor.md
FLL_WORDCNT_MONITOR -- requirements
Module: fll_wordcnt_monitor

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of independent master/local bitclk pairs (1..4).
REQ-002 SHALL have parameter BITS_PER_WORD, default 32: bitclk rising edges per word (2..256).
REQ-003 SHALL have parameter CNT_W, default 8: width of the signed per-channel word-difference counter (4..16).
REQ-004 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for bitclk inputs (2..3).
REQ-005 SHALL have port CLK_IP_i, input, 1: the single sampling clock; all state is in this domain.
REQ-006 SHALL have port RST_IP_n_i, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port bitclk_master_i, input, N_CH: per-channel master bitclks, asynchronous to CLK_IP_i.
REQ-008 SHALL have port bitclk_local_i, input, N_CH: per-channel local bitclks, asynchronous to CLK_IP_i.
REQ-009 SHALL have port enable_i, input, N_CH: per-channel monitor enable.
REQ-010 SHALL have port thresh_i, input, CNT_W-1: unsigned assert threshold in words, shared by all channels.
REQ-011 SHALL have port clr_i, input, N_CH: per-channel single-cycle clear pulse.
REQ-012 SHALL have port speedup_o, output, N_CH: level interrupt; local is behind master.
REQ-013 SHALL have port slowdown_o, output, N_CH: level interrupt; local is ahead of master.
REQ-014 SHALL have port diff_o, output, N_CH*CNT_W: packed signed differences; channel k occupies bits [k*CNT_W +: CNT_W].
REQ-015 SHALL have port overflow_o, output, N_CH: sticky saturation flag.

Function
REQ-016 SHALL synchronise each bitclk through SYNC_STAGES flops; an edge is detected when the synchronised value is 1 and the previous value was 0.
REQ-017 SHALL operate correctly when CLK_IP_i is at least 4x the fastest bitclk; behaviour below this rate is undefined.
REQ-018 SHALL keep per channel, per side, a bit counter 0..BITS_PER_WORD-1 that increments on each detected edge; the wrap from BITS_PER_WORD-1 to 0 produces a one-cycle word tick.
REQ-019 SHALL update diff by +1 on a master tick only, by -1 on a local tick only, and leave it unchanged on simultaneous ticks.
REQ-020 SHALL saturate diff at +(2^(CNT_W-1)-1) and -(2^(CNT_W-1)); an increment or decrement attempted at the limit leaves diff unchanged and sets overflow_o, which is cleared only by clr_i or reset.
REQ-021 SHALL implement a per-channel state machine with states IDLE, TRACK, SPEEDUP and SLOWDOWN.
REQ-022 SHALL hold the channel in IDLE whenever enable_i=0; in IDLE, counters, diff and overflow are held at 0 and both interrupts are 0.
REQ-023 SHALL move from IDLE to TRACK on the first cycle enable_i=1, with the counters starting from 0.
REQ-024 SHALL move from TRACK to SPEEDUP when diff >= T, and from TRACK to SLOWDOWN when diff <= -T, where T = thresh_i, or 1 if thresh_i = 0.
REQ-025 SHALL provide hysteresis: SPEEDUP returns to TRACK when diff <= 0; SLOWDOWN returns to TRACK when diff >= 0.
REQ-026 SHALL, on clr_i in any non-IDLE state, go to TRACK on the next cycle and zero diff, both bit counters and overflow; clr_i overrides a same-cycle tick.
REQ-027 SHALL compute the state transition from the registered diff, so a transition occurs 1 cycle after the diff update.
REQ-028 SHALL register speedup_o and slowdown_o directly from the state (SPEEDUP and SLOWDOWN respectively); they are never both 1.
REQ-029 SHALL give a bitclk-edge-to-diff_o latency of SYNC_STAGES+2 CLK_IP_i cycles, and an edge-to-interrupt latency of SYNC_STAGES+3 cycles.
REQ-030 SHALL keep channels fully independent; clr_i, enable_i and saturation on one channel do not affect another.
REQ-031 SHALL apply a change of thresh_i in the cycle after the change, with no state reset.

Reset
REQ-032 SHALL, while RST_IP_n_i=0, asynchronously force all states to IDLE, all counters, synchronisers, diff_o, speedup_o, slowdown_o and overflow_o to 0; release is synchronous to CLK_IP_i.
REQ-033 SHALL, after reset is released, resume in IDLE and proceed per enable_i; reset asserted mid-word discards partial counts.

Verification (N_CH=2, BITS_PER_WORD=32, CNT_W=8, SYNC_STAGES=2)
REQ-034 SHALL be verified with reset asserted mid-operation while diff=+5 and speedup=1 -> all outputs 0 immediately; after release with enable=0, all outputs stay 0.
REQ-035 SHALL be verified with thresh=3 and both bitclks of ch0 at a 10-cycle period, offset 3 cycles, for 100 words -> diff_o[0] stays within +/-1 and no interrupts assert.
REQ-036 SHALL be verified with thresh=3, master at a 10-cycle period and local at an 11-cycle period -> speedup_o[0]=1 exactly SYNC_STAGES+3 cycles after the master edge making diff=+3; then, with the local period set to 9, speedup_o[0] deasserts once diff reaches 0.
REQ-037 SHALL be verified with thresh=127, master running and local stopped -> diff_o[0] holds at +127, and overflow_o[0] rises at master word 128.
REQ-038 SHALL be verified with ch1 in SLOWDOWN and diff=-4 while ch0 is in TRACK, then a clr_i[1] pulse -> next cycle slowdown_o[1]=0 and diff_o[1]=0, with ch0 unchanged.
REQ-039 SHALL be verified with master and local word ticks forced into the same cycle -> diff unchanged; and with enable_i[0] dropped mid-word -> IDLE and diff=0 next cycle.
